// File: rtl/ro_scheduler.sv
// Time-slot readout scheduler: a binary slot counter whose trailing-ones count picks
// the channel to serve, with per-channel event capture, pending and overrun tracking.
module ro_scheduler #(
  parameter int NCH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [NCH-1:0] din_pol,
  input  logic [NCH-1:0] din_eve,
  input  logic           clr_ovf,
  output logic [NCH-1:0] gray,
  output logic [NCH-1:0] grant,
  output logic           frame,
  output logic           dout_pol,
  output logic           dout_eve,
  output logic           dout_valid,
  output logic [2:0]     ch_idx,
  output logic [NCH-1:0] ovf
);

  localparam logic [NCH-1:0] ONE = {{(NCH-1){1'b0}}, 1'b1};

  logic [NCH-1:0] bin_q, bin_d;
  logic [NCH-1:0] gray_q, gray_d;
  logic [NCH-1:0] grant_q, grant_d;
  logic           frame_q, frame_d;
  logic           dout_pol_q, dout_pol_d;
  logic           dout_eve_q, dout_eve_d;
  logic           dout_valid_q, dout_valid_d;
  logic [2:0]     ch_idx_q, ch_idx_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [NCH-1:0] pend_pol_q, pend_pol_d;
  logic [NCH-1:0] pend_eve_q, pend_eve_d;
  logic [NCH-1:0] prev_pol_q, prev_pol_d;
  logic [NCH-1:0] prev_eve_q, prev_eve_d;

  logic [NCH-1:0] edge_pol, edge_eve;
  logic [NCH-1:0] slot_mask, cap;
  logic [NCH-1:0] ovf_set;
  logic [2:0]     slot_idx;

  // Lowest zero bit of bin is the served channel; all-ones gives an empty mask (frame slot).
  assign slot_mask = ~bin_q & (bin_q + ONE);

  always_comb begin
    slot_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (slot_mask[i]) slot_idx = 3'(i);
    end
  end

  always_comb begin
    edge_pol     = din_pol & ~prev_pol_q;
    edge_eve     = din_eve & ~prev_eve_q;
    cap          = en ? slot_mask : '0;

    bin_d        = en ? (bin_q + ONE) : bin_q;
    gray_d       = bin_d ^ (bin_d >> 1);
    grant_d      = cap;
    frame_d      = en & (&bin_q);
    dout_valid_d = |cap;
    ch_idx_d     = ch_idx_q;
    dout_pol_d   = dout_pol_q;
    dout_eve_d   = dout_eve_q;
    if (|cap) begin
      ch_idx_d   = slot_idx;
      // An edge arriving in the capture cycle itself is delivered, not left pending.
      dout_pol_d = |(cap & (pend_pol_q | edge_pol));
      dout_eve_d = |(cap & (pend_eve_q | edge_eve));
    end

    pend_pol_d   = (pend_pol_q | edge_pol) & ~cap;
    pend_eve_d   = (pend_eve_q | edge_eve) & ~cap;
    ovf_set      = ((edge_pol & pend_pol_q) | (edge_eve & pend_eve_q)) & ~cap;
    ovf_d        = clr_ovf ? ovf_set : (ovf_q | ovf_set);

    prev_pol_d   = din_pol;
    prev_eve_d   = din_eve;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q        <= '0;
      gray_q       <= '0;
      grant_q      <= '0;
      frame_q      <= 1'b0;
      dout_pol_q   <= 1'b0;
      dout_eve_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      ch_idx_q     <= '0;
      ovf_q        <= '0;
      pend_pol_q   <= '0;
      pend_eve_q   <= '0;
      prev_pol_q   <= '0;
      prev_eve_q   <= '0;
    end else begin
      bin_q        <= bin_d;
      gray_q       <= gray_d;
      grant_q      <= grant_d;
      frame_q      <= frame_d;
      dout_pol_q   <= dout_pol_d;
      dout_eve_q   <= dout_eve_d;
      dout_valid_q <= dout_valid_d;
      ch_idx_q     <= ch_idx_d;
      ovf_q        <= ovf_d;
      pend_pol_q   <= pend_pol_d;
      pend_eve_q   <= pend_eve_d;
      prev_pol_q   <= prev_pol_d;
      prev_eve_q   <= prev_eve_d;
    end
  end

  assign gray       = gray_q;
  assign grant      = grant_q;
  assign frame      = frame_q;
  assign dout_pol   = dout_pol_q;
  assign dout_eve   = dout_eve_q;
  assign dout_valid = dout_valid_q;
  assign ch_idx     = ch_idx_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_ro_scheduler.sv
// Bench for ro_scheduler: a slot-level behavioural model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_ro_scheduler;

  localparam int NCH = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic           clr_ovf;
  logic [NCH-1:0] din_pol;
  logic [NCH-1:0] din_eve;
  logic [NCH-1:0] gray;
  logic [NCH-1:0] grant;
  logic           frame;
  logic           dout_pol;
  logic           dout_eve;
  logic           dout_valid;
  logic [2:0]     ch_idx;
  logic [NCH-1:0] ovf;

  ro_scheduler #(.NCH(NCH)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .din_pol    (din_pol),
    .din_eve    (din_eve),
    .clr_ovf    (clr_ovf),
    .gray       (gray),
    .grant      (grant),
    .frame      (frame),
    .dout_pol   (dout_pol),
    .dout_eve   (dout_eve),
    .dout_valid (dout_valid),
    .ch_idx     (ch_idx),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // Model state: slot number as a plain integer, pending/overrun as bit sets.
  int       m_bin;
  bit [7:0] m_gray, m_grant, m_ovf, m_pp, m_pe, m_prev_p, m_prev_e;
  bit       m_frame, m_valid, m_dp, m_de;
  int       m_ch;

  always @(posedge clk or posedge reset) begin : model
    bit [7:0] ep, ee, setb;
    int       k, nb;
    if (reset) begin
      m_bin <= 0; m_gray <= '0; m_grant <= '0; m_frame <= 1'b0; m_valid <= 1'b0;
      m_ch <= 0; m_dp <= 1'b0; m_de <= 1'b0; m_ovf <= '0; m_pp <= '0; m_pe <= '0;
      m_prev_p <= '0; m_prev_e <= '0;
    end else begin
      ep = din_pol & ~m_prev_p;
      ee = din_eve & ~m_prev_e;
      k  = -1;
      m_grant <= '0;
      m_frame <= 1'b0;
      m_valid <= 1'b0;
      if (en) begin
        // Served index = position of lowest zero bit = log2 of the bit flipped on to increment.
        k = $clog2((m_bin + 1) & ~m_bin);
        if (k < NCH) begin
          m_grant <= 8'(1 << k);
          m_valid <= 1'b1;
          m_ch    <= k;
          m_dp    <= m_pp[k] | ep[k];
          m_de    <= m_pe[k] | ee[k];
        end else begin
          m_frame <= 1'b1;
        end
        nb = (m_bin + 1) % 256;
        m_bin  <= nb;
        m_gray <= 8'(nb ^ (nb >> 1));
      end
      setb = '0;
      for (int i = 0; i < NCH; i++) begin
        if (i != k && ((ep[i] && m_pp[i]) || (ee[i] && m_pe[i]))) setb[i] = 1'b1;
      end
      m_ovf <= clr_ovf ? setb : (m_ovf | setb);
      for (int i = 0; i < NCH; i++) begin
        m_pp[i] <= (i == k) ? 1'b0 : (m_pp[i] | ep[i]);
        m_pe[i] <= (i == k) ? 1'b0 : (m_pe[i] | ee[i]);
      end
      m_prev_p <= din_pol;
      m_prev_e <= din_eve;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock, then compare every output against the model on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("gray",     32'(gray),       32'(m_gray));
    chk("grant",    32'(grant),      32'(m_grant));
    chk("frame",    32'(frame),      32'(m_frame));
    chk("valid",    32'(dout_valid), 32'(m_valid));
    chk("ch_idx",   32'(ch_idx),     32'(m_ch));
    chk("dout_pol", 32'(dout_pol),   32'(m_dp));
    chk("dout_eve", 32'(dout_eve),   32'(m_de));
    chk("ovf",      32'(ovf),        32'(m_ovf));
  endtask

  int       g0, g7, fr, bad_gray, vp, held_bad;
  bit [7:0] prev_g;
  bit [7:0] gseq [4] = '{8'h01, 8'h03, 8'h02, 8'h06};

  initial begin
    reset = 1'b1; en = 1'b0; clr_ovf = 1'b0; din_pol = '0; din_eve = '0;
    repeat (2) @(negedge clk);
    chk("rst_gray",  32'(gray),       0);
    chk("rst_grant", 32'(grant),      0);
    chk("rst_frame", 32'(frame),      0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_ovf",   32'(ovf),        0);
    $display("reset state checked");

    reset = 1'b0; en = 1'b1;
    g0 = 0; g7 = 0; fr = 0; bad_gray = 0; vp = 0; prev_g = '0;
    for (int c = 0; c < 256; c++) begin
      step();
      g0 += int'(grant[0]);
      g7 += int'(grant[7]);
      fr += int'(frame);
      if ($countones(gray ^ prev_g) != 1) bad_gray++;
      prev_g = gray;
      if (dout_valid && dout_pol) vp++;
      if (c == 0) begin
        chk("first_grant", 32'(grant), 32'h01);
        chk("first_gray",  32'(gray),  32'h01);
      end
      if (c == 255) chk("frame_at_ff", 32'(frame), 1);
    end
    chk("grant0_count", 32'(g0), 128);
    chk("grant7_count", 32'(g7), 1);
    chk("frame_count",  32'(fr), 1);
    chk("gray_steps",   32'(bad_gray), 0);
    chk("idle_pol",     32'(vp), 0);
    $display("free-run frame: grant0=%0d grant7=%0d frame=%0d", g0, g7, fr);

    for (int c = 0; c < 24; c++) begin
      din_pol = (c == 0) ? 8'h08 : 8'h00;
      din_eve = (c == 3) ? 8'h04 : 8'h00;
      step();
      if (c == 3) begin
        chk("eve2_valid", 32'(dout_valid), 1);
        chk("eve2_idx",   32'(ch_idx),     2);
        chk("eve2_eve",   32'(dout_eve),   1);
        chk("eve2_ovf",   32'(ovf[2]),     0);
      end
      if (c == 7) begin
        chk("pol3_valid", 32'(dout_valid), 1);
        chk("pol3_idx",   32'(ch_idx),     3);
        chk("pol3_pol",   32'(dout_pol),   1);
        chk("pol3_eve",   32'(dout_eve),   0);
      end
      if (c == 11) chk("eve2_cleared", 32'(dout_eve), 0);
      if (c == 23) begin
        chk("pol3_next_idx", 32'(ch_idx),   3);
        chk("pol3_cleared",  32'(dout_pol), 0);
      end
    end
    din_pol = '0; din_eve = '0;
    $display("capture scenarios done");

    for (int c = 24; c < 37; c++) begin
      din_pol = (c == 24 || c == 26 || c == 33 || c == 35) ? 8'h20 : 8'h00;
      clr_ovf = (c == 32 || c == 35);
      step();
      if (c == 26) chk("ovf5_set", 32'(ovf[5]), 1);
      if (c == 31) begin
        chk("ovf5_cap_idx", 32'(ch_idx),   5);
        chk("ovf5_cap_pol", 32'(dout_pol), 1);
        chk("ovf5_sticky",  32'(ovf[5]),   1);
      end
      if (c == 32) chk("ovf5_cleared", 32'(ovf[5]), 0);
      if (c == 35) chk("ovf5_set_wins", 32'(ovf[5]), 1);
    end
    din_pol = '0; clr_ovf = 1'b0;
    $display("overrun scenario done");

    en = 1'b0; held_bad = 0;
    for (int j = 0; j < 10; j++) begin
      din_pol = (j == 3) ? 8'h02 : 8'h00;
      step();
      if (gray != 8'h37 || grant != '0 || frame || dout_valid) held_bad++;
    end
    chk("pause_held", 32'(held_bad), 0);
    din_pol = '0; en = 1'b1;
    step();
    chk("pause_idx",   32'(ch_idx),     1);
    chk("pause_valid", 32'(dout_valid), 1);
    chk("pause_pol",   32'(dout_pol),   1);
    chk("pause_gray",  32'(gray),       32'h35);
    $display("pause scenario done");

    din_eve = 8'h40;
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_gray",  32'(gray),       0);
    chk("mid_rst_grant", 32'(grant),      0);
    chk("mid_rst_frame", 32'(frame),      0);
    chk("mid_rst_valid", 32'(dout_valid), 0);
    chk("mid_rst_dout",  32'({dout_pol, dout_eve}), 0);
    chk("mid_rst_idx",   32'(ch_idx),     0);
    chk("mid_rst_ovf",   32'(ovf),        0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 70; c++) begin
      step();
      if (c < 4) chk("restart_gray", 32'(gray), 32'(gseq[c]));
      if (c == 63) begin
        chk("held_line_idx", 32'(ch_idx),   6);
        chk("held_line_eve", 32'(dout_eve), 1);
      end
    end
    $display("mid-frame reset scenario done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
